// File: rtl/ip_dispatch_pipe.sv
// Five-stage command dispatcher: fetch/decode instruction words, optionally read
// data memory, and hand the result to one of NUM_CH accelerator channels.
module ip_dispatch_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 20,
    parameter int PC_W   = 32,
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    output logic              imem_en,
    output logic [PC_W-3:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_en,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [NUM_CH-1:0] ip_valid,
    input  logic [NUM_CH-1:0] ip_ready,
    output logic [DATA_W-1:0] ip_data,
    output logic              halted,
    output logic              idle,
    output logic [PC_W-1:0]   pc_out,
    output logic [15:0]       sent_count,
    output logic              bad_ch
);
    localparam int STAGES = 4;  // D, E, M, O
    localparam logic [5:0] OP_LOAD = 6'h01;
    localparam logic [5:0] OP_SEND = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [PC_W-1:0]   pc;
    logic [STAGES:1]   vld_pipe;
    logic              e_load, m_load;
    logic [ADDR_W-1:0] e_addr, m_addr;
    logic [CH_W-1:0]   e_ch, m_ch, o_ch;
    logic [DATA_W-1:0] o_data, m_result;

    logic              stall, fetch, xfer, halt_d, d_is_send, d_bad, d_send;
    logic [5:0]        d_op;
    logic [ADDR_W-1:0] d_addr;
    logic [CH_W-1:0]   d_ch;
    logic [NUM_CH-1:0] o_sel;
    logic              unused_bits;

    assign d_op      = imem_rdata[30:25];
    assign d_addr    = imem_rdata[5+ADDR_W-1:5];
    assign d_ch      = imem_rdata[CH_W-1:0];
    assign d_is_send = (d_op == OP_LOAD) || (d_op == OP_SEND);
    // Out-of-range channels are dropped in D so O never sees an unselectable channel.
    assign d_bad     = vld_pipe[1] && d_is_send && (32'(d_ch) >= 32'(NUM_CH));
    assign d_send    = vld_pipe[1] && d_is_send && !d_bad;

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            o_sel[i] = vld_pipe[STAGES] && (32'(o_ch) == 32'(i));
    end

    assign xfer   = |(o_sel & ip_ready);
    assign stall  = vld_pipe[STAGES] && !xfer;
    assign halt_d = vld_pipe[1] && (d_op == OP_HALT) && !stall;
    assign fetch  = run && !halted && !stall && !rst;

    assign imem_en   = fetch;
    assign imem_addr = pc[PC_W-1:2];
    assign dmem_en   = vld_pipe[2] && e_load && !stall && !rst;
    assign dmem_addr = e_addr;
    assign m_result  = m_load ? dmem_rdata : DATA_W'(m_addr);

    assign ip_valid = o_sel;
    assign ip_data  = o_data;
    assign pc_out   = pc;
    assign idle     = halted && !(|vld_pipe);

    assign unused_bits = ^{imem_rdata, pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            halted     <= 1'b0;
            vld_pipe   <= '0;
            e_load     <= 1'b0;
            e_addr     <= '0;
            e_ch       <= '0;
            m_load     <= 1'b0;
            m_addr     <= '0;
            m_ch       <= '0;
            o_data     <= '0;
            o_ch       <= '0;
            sent_count <= '0;
            bad_ch     <= 1'b0;
        end else begin
            if (d_bad) bad_ch <= 1'b1;
            if (xfer) sent_count <= sent_count + 16'd1;

            if (halted) begin
                if (start) begin
                    halted <= 1'b0;
                    pc     <= start_pc;
                end
            end else if (halt_d) begin
                halted <= 1'b1;
            end else if (fetch) begin
                pc <= pc + PC_W'(4);
            end

            // Whole pipe advances together; the instruction fetched alongside HALT is squashed.
            if (!stall) begin
                vld_pipe <= {vld_pipe[STAGES-1:2], d_send, fetch && !halt_d};
                if (d_send) begin
                    e_load <= (d_op == OP_LOAD);
                    e_addr <= d_addr;
                    e_ch   <= d_ch;
                end
                if (vld_pipe[2]) begin
                    m_load <= e_load;
                    m_addr <= e_addr;
                    m_ch   <= e_ch;
                end
                if (vld_pipe[3]) begin
                    o_data <= m_result;
                    o_ch   <= m_ch;
                end
            end
        end
    end
endmodule

// File: tb/tb_ip_dispatch_pipe.sv
// Scoreboard bench for ip_dispatch_pipe: behavioural memories, expected transfers
// queued as each program is loaded, popped as the DUT hands data off.
module tb_ip_dispatch_pipe;
    logic        clk = 1'b0;
    logic        rst, run, start;
    logic [31:0] start_pc;
    logic        imem_en, dmem_en;
    logic [29:0] imem_addr;
    logic [31:0] imem_rdata, dmem_rdata;
    logic [19:0] dmem_addr;
    logic [1:0]  ip_valid, ip_ready;
    logic [31:0] ip_data, pc_out;
    logic        halted, idle, bad_ch;
    logic [15:0] sent_count;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    logic [39:0] sb [$];
    int checks = 0, errors = 0;
    int cyc = 0, n_xfer, first_x, last_x;
    logic [31:0] pc_snap;

    ip_dispatch_pipe #(.NUM_CH(2), .CH_W(2)) dut (
        .clk(clk), .rst(rst), .run(run), .start(start), .start_pc(start_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .ip_valid(ip_valid), .ip_ready(ip_ready), .ip_data(ip_data),
        .halted(halted), .idle(idle), .pc_out(pc_out),
        .sent_count(sent_count), .bad_ch(bad_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem[imem_addr[7:0]];
        if (dmem_en) dmem_rdata <= dmem[dmem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [19:0] a, input logic [1:0] ch);
        return {1'b0, op, a, 3'b000, ch};
    endfunction

    // Transfer happens at the next posedge; sampled here on the falling edge.
    always @(negedge clk) begin
        if (!rst && (ip_valid & ip_ready) != 2'b00) begin
            logic [39:0] got;
            chk("onehot", 64'($onehot(ip_valid)), 64'd1);
            got = {8'(ip_valid[1] ? 1 : 0), ip_data};
            chk("xfer_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) chk("xfer_word", 64'(got), 64'(sb.pop_front()));
            if (n_xfer == 0) first_x = cyc;
            last_x = cyc;
            n_xfer++;
        end
    end

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        sb.delete();
    endtask

    task automatic rst_dut(input logic run_after);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; run = run_after; n_xfer = 0;
    endtask

    task automatic wait_drain(input string tag, input int max);
        for (int i = 0; i < max && sb.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; start = 1'b0; start_pc = 32'h0; ip_ready = 2'b11;

        // 1: reset values, then single LOAD_SEND latency
        clr_mem();
        dmem[8'h10] = 32'hDEADBEEF;
        imem[0] = mk(6'h01, 20'h10, 2'd1);
        sb.push_back({8'd1, 32'hDEADBEEF});
        @(posedge clk); #1; rst = 1'b1; run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ip_valid", 64'(ip_valid), 64'd0);
        chk("rst_ip_data", 64'(ip_data), 64'd0);
        chk("rst_imem_en", 64'(imem_en), 64'd0);
        chk("rst_dmem_en", 64'(dmem_en), 64'd0);
        chk("rst_dmem_addr", 64'(dmem_addr), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_idle", 64'(idle), 64'd0);
        chk("rst_pc", 64'(pc_out), 64'd0);
        chk("rst_sent", 64'(sent_count), 64'd0);
        chk("rst_bad_ch", 64'(bad_ch), 64'd0);
        @(posedge clk); #1; rst = 1'b0; n_xfer = 0;
        @(negedge clk);
        chk("t1_fetch_en", 64'(imem_en), 64'd1);
        chk("t1_fetch_addr", 64'(imem_addr), 64'd0);
        repeat (3) @(negedge clk);
        chk("t1_lat_early", 64'(ip_valid), 64'd0);
        @(negedge clk);
        chk("t1_lat_valid", 64'(ip_valid), 64'h2);
        chk("t1_lat_data", 64'(ip_data), 64'hDEADBEEF);
        wait_drain("t1_drain", 20);
        chk("t1_sent", 64'(sent_count), 64'd1);

        // 2: back-to-back SEND_ADDR, one per cycle
        clr_mem();
        for (int i = 0; i < 4; i++) begin
            imem[i] = mk(6'h02, 20'(i + 1), 2'd0);
            sb.push_back({8'd0, 32'(i + 1)});
        end
        rst_dut(1'b1);
        wait_drain("t2_drain", 30);
        chk("t2_consecutive", 64'(last_x - first_x), 64'd3);
        chk("t2_sent", 64'(sent_count), 64'd4);

        // 3: backpressure freezes the pipe and holds the output word
        clr_mem();
        ip_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            dmem[8'h20 + i] = 32'hA000_0000 + 32'(i);
            imem[i] = mk(6'h01, 20'(32'h20 + i), 2'd0);
            sb.push_back({8'd0, 32'hA000_0000 + 32'(i)});
        end
        rst_dut(1'b1);
        for (int i = 0; i < 30 && ip_valid != 2'b01; i++) @(negedge clk);
        chk("t3_valid_seen", 64'(ip_valid), 64'h1);
        pc_snap = pc_out;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(ip_valid), 64'h1);
            chk("t3_hold_data", 64'(ip_data), 64'hA000_0000);
            chk("t3_hold_imem_en", 64'(imem_en), 64'd0);
            chk("t3_hold_dmem_en", 64'(dmem_en), 64'd0);
            chk("t3_hold_pc", 64'(pc_out), 64'(pc_snap));
            @(negedge clk);
        end
        @(posedge clk); #1; ip_ready = 2'b11;
        wait_drain("t3_drain", 30);
        repeat (5) @(negedge clk);
        chk("t3_sent", 64'(sent_count), 64'd3);

        // 4: HALT squashes the following fetch; start resumes
        clr_mem();
        imem[0] = mk(6'h02, 20'd7, 2'd0);
        imem[1] = mk(6'h3F, 20'd0, 2'd0);
        imem[2] = mk(6'h02, 20'd9, 2'd0);
        sb.push_back({8'd0, 32'd7});
        rst_dut(1'b1);
        wait_drain("t4_drain_a", 30);
        repeat (3) @(negedge clk);
        chk("t4_halted", 64'(halted), 64'd1);
        chk("t4_pc", 64'(pc_out), 64'd8);
        chk("t4_idle", 64'(idle), 64'd1);
        chk("t4_sent_a", 64'(sent_count), 64'd1);
        sb.push_back({8'd0, 32'd9});
        @(posedge clk); #1; start = 1'b1; start_pc = 32'd8;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("t4_unhalted", 64'(halted), 64'd0);
        wait_drain("t4_drain_b", 30);
        chk("t4_sent_b", 64'(sent_count), 64'd2);

        // 5: out-of-range channel dropped, sticky flag
        clr_mem();
        imem[0] = mk(6'h02, 20'd5, 2'd3);
        imem[1] = mk(6'h02, 20'd6, 2'd1);
        sb.push_back({8'd1, 32'd6});
        rst_dut(1'b1);
        @(negedge clk);
        chk("t5_bad_clear", 64'(bad_ch), 64'd0);
        wait_drain("t5_drain", 30);
        chk("t5_bad_set", 64'(bad_ch), 64'd1);
        repeat (4) @(negedge clk);
        chk("t5_bad_sticky", 64'(bad_ch), 64'd1);
        chk("t5_sent", 64'(sent_count), 64'd1);

        // 6: reset while stalled discards the pending word
        clr_mem();
        ip_ready = 2'b00;
        imem[0] = mk(6'h02, 20'h33, 2'd1);
        sb.push_back({8'd1, 32'h33});
        rst_dut(1'b1);
        for (int i = 0; i < 30 && ip_valid != 2'b10; i++) @(negedge clk);
        chk("t6_stalled_valid", 64'(ip_valid), 64'h2);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; run = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t6_valid_cleared", 64'(ip_valid), 64'd0);
        chk("t6_sent", 64'(sent_count), 64'd0);
        chk("t6_pc", 64'(pc_out), 64'd0);
        ip_ready = 2'b11;
        repeat (5) @(negedge clk);
        chk("t6_no_xfer", 64'(sent_count), 64'd0);
        chk("t6_valid_idle", 64'(ip_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
